frog_motion: RTL and testbench

FROG_MOTION -- requirements
Module: frog_motion

---
 rtl/frog_motion_if.sv | 22 ++
 rtl/frog_motion.sv | 172 +++++++++++++++++
 tb/tb_frog_motion.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/frog_motion_if.sv
// Pixel-side bus of the frog sprite: draw coordinate and ROM data in,
// ROM address/select and the registered pixel result out.
interface frog_motion_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic [7:0] rom_data;
   logic [4:0] DX;
   logic [4:0] DY;
   logic [2:0] dir;
   logic       is_frog;
   logic [7:0] frog_color_idx;

   modport master (
      output DrawX, DrawY, rom_data,
      input  DX, DY, dir, is_frog, frog_color_idx
   );

   modport slave (
      input  DrawX, DrawY, rom_data,
      output DX, DY, dir, is_frog, frog_color_idx
   );
endinterface

// File: rtl/frog_motion.sv
// Grid-stepping frog: one jump of GRID pixels per key press, spread over JUMP_FRAMES frames.
// Define FROG_HOLD_REPEAT_EN to let a held key auto-repeat jumps (no WAIT_RELEASE state).
//
// state        | meaning
// S_IDLE       | standing; a direction key on a frame tick turns and maybe starts a jump
// S_JUMP       | moving GRID/JUMP_FRAMES pixels per frame tick until the jump is done
// S_WAIT_REL   | jump done; waits for a frame tick with no key (absent in repeat build)
module frog_motion #(
   parameter int GRID        = 24,
   parameter int JUMP_FRAMES = 8,
   parameter int X_MIN       = 8,
   parameter int X_MAX       = 608,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 456,
   parameter int X_START     = 296,
   parameter int Y_START     = 456
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          frame_clk,
   input  logic [7:0]    keycode,
   output logic [9:0]    frog_x,
   output logic [9:0]    frog_y,
   frog_motion_if.slave  pix
);

   localparam int         STEP     = GRID / JUMP_FRAMES;
   localparam int         CW       = $clog2(JUMP_FRAMES + 1);
   localparam logic [9:0] STEP10   = 10'(STEP);
   localparam logic [10:0] GRID11  = 11'(GRID);
   localparam logic [10:0] X_MIN11 = 11'(X_MIN);
   localparam logic [10:0] Y_MIN11 = 11'(Y_MIN);
   localparam logic [10:0] X_SPAN  = 11'(X_MAX - X_MIN);
   localparam logic [10:0] Y_SPAN  = 11'(Y_MAX - Y_MIN);
   localparam logic [CW-1:0] CNT_DONE = CW'(JUMP_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
`ifdef FROG_HOLD_REPEAT_EN
      S_JUMP     = 2'd1
`else
      S_JUMP     = 2'd1,
      S_WAIT_REL = 2'd2
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      facing_q, facing_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [9:0]      x_q, x_d;
   logic [9:0]      y_q, y_d;
   logic            frame_clk_q;
   logic            is_frog_q, is_frog_d;
   logic [7:0]      color_q, color_d;

   logic            frame_tick;
   logic            key_valid;
   logic [1:0]      key_dir;
   logic [10:0]     tx, ty;
   logic            target_ok;
   logic [CW-1:0]   cnt_inc;
   logic            in_box;

   assign frame_tick = frame_clk & ~frame_clk_q;
   assign cnt_inc    = cnt_q + CW'(1);

   always_comb begin
      key_valid = 1'b1;
      key_dir   = 2'd0;
      case (keycode)
         8'h1A:   key_dir = 2'd0;
         8'h07:   key_dir = 2'd1;
         8'h16:   key_dir = 2'd2;
         8'h04:   key_dir = 2'd3;
         default: key_valid = 1'b0;
      endcase
   end

   // Target cell in 11 bits: moving below 0 wraps past 1023, which the span test rejects.
   always_comb begin
      tx = {1'b0, x_q};
      ty = {1'b0, y_q};
      case (key_dir)
         2'd0:    ty = {1'b0, y_q} - GRID11;
         2'd1:    tx = {1'b0, x_q} + GRID11;
         2'd2:    ty = {1'b0, y_q} + GRID11;
         default: tx = {1'b0, x_q} - GRID11;
      endcase
      target_ok = (11'(tx - X_MIN11) <= X_SPAN) && (11'(ty - Y_MIN11) <= Y_SPAN);
   end

   always_comb begin
      state_d  = state_q;
      facing_d = facing_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      case (state_q)
         S_IDLE: begin
            if (frame_tick && key_valid) begin
               facing_d = key_dir;
               if (target_ok) begin
                  state_d = S_JUMP;
                  cnt_d   = '0;
               end
            end
         end
         S_JUMP: begin
            if (frame_tick) begin
               case (facing_q)
                  2'd0:    y_d = y_q - STEP10;
                  2'd1:    x_d = x_q + STEP10;
                  2'd2:    y_d = y_q + STEP10;
                  default: x_d = x_q - STEP10;
               endcase
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_DONE) begin
`ifdef FROG_HOLD_REPEAT_EN
                  state_d = S_IDLE;
`else
                  state_d = S_WAIT_REL;
`endif
               end
            end
         end
`ifndef FROG_HOLD_REPEAT_EN
         S_WAIT_REL: begin
            if (frame_tick && (keycode == 8'h00)) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_box = (pix.DrawX >= x_q) && ({1'b0, pix.DrawX} < ({1'b0, x_q} + GRID11)) &&
               (pix.DrawY >= y_q) && ({1'b0, pix.DrawY} < ({1'b0, y_q} + GRID11));
      pix.DX    = in_box ? 5'(pix.DrawX - x_q) : 5'd0;
      pix.DY    = in_box ? 5'(pix.DrawY - y_q) : 5'd0;
      is_frog_d = in_box && (pix.rom_data != 8'h00);
      color_d   = in_box ? pix.rom_data : 8'h00;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         facing_q    <= 2'd0;
         cnt_q       <= '0;
         x_q         <= 10'(X_START);
         y_q         <= 10'(Y_START);
         frame_clk_q <= 1'b0;
         is_frog_q   <= 1'b0;
         color_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         facing_q    <= facing_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         frame_clk_q <= frame_clk;
         is_frog_q   <= is_frog_d;
         color_q     <= color_d;
      end
   end

   assign pix.dir            = {(state_q == S_JUMP), facing_q};
   assign pix.is_frog        = is_frog_q;
   assign pix.frog_color_idx = color_q;
   assign frog_x             = x_q;
   assign frog_y             = y_q;

endmodule

// File: tb/tb_frog_motion.sv
// Directed bench for frog_motion: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them on the cycle they fall due.
module tb_frog_motion;

   localparam int SIG_X = 0, SIG_Y = 1, SIG_DIR = 2, SIG_ISF = 3, SIG_COL = 4, SIG_DX = 5, SIG_DY = 6;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [9:0] frog_x, frog_y;

   frog_motion_if pif();

   frog_motion dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .keycode   (keycode),
      .frog_x    (frog_x),
      .frog_y    (frog_y),
      .pix       (pif)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int    due;
      int    sig;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic int actual(input int sig);
      case (sig)
         SIG_X:   return int'(frog_x);
         SIG_Y:   return int'(frog_y);
         SIG_DIR: return int'(pif.dir);
         SIG_ISF: return int'(pif.is_frog);
         SIG_COL: return int'(pif.frog_color_idx);
         SIG_DX:  return int'(pif.DX);
         default: return int'(pif.DY);
      endcase
   endfunction

   always @(negedge Clk) begin
      exp_t e;
      int   a;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         n_chk++;
         a = actual(e.sig);
         if (e.due < cyc)
            $display("FAIL %s: stale expectation (due %0d, now %0d)", e.name, e.due, cyc);
         else if (a != e.val)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
         else
            n_pass++;
      end
   end

   task automatic expect_at(input int ofs, input int sig, input int val, input string name);
      exp_t e;
      e.due = cyc + ofs; e.sig = sig; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // One frame: frame_clk high for a cycle (tick acts on the first edge), then low.
   task automatic tick(input logic [7:0] key);
      keycode   = key;
      frame_clk = 1'b1;
      step(1);
      frame_clk = 1'b0;
      step(1);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step(2);
      Reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset       = 1'b1;
      frame_clk   = 1'b0;
      keycode     = 8'h00;
      pif.DrawX   = 10'd0;
      pif.DrawY   = 10'd0;
      pif.rom_data = 8'h00;
      step(3);
      expect_at(0, SIG_X, 296, "reset_x");
      expect_at(0, SIG_Y, 456, "reset_y");
      expect_at(0, SIG_DIR, 0, "reset_dir");
      expect_at(0, SIG_ISF, 0, "reset_is_frog");
      expect_at(0, SIG_COL, 0, "reset_color");
      Reset = 1'b0;
      step(1);

      repeat (3) tick(8'h00);
      expect_at(0, SIG_X, 296, "idle_x");
      expect_at(0, SIG_Y, 456, "idle_y");
      expect_at(0, SIG_DIR, 0, "idle_dir");
      expect_at(0, SIG_ISF, 0, "idle_is_frog");

      // sprite pixel lookup at (296,456)
      pif.DrawX = 10'd300; pif.DrawY = 10'd460; pif.rom_data = 8'd5;
      expect_at(0, SIG_DX, 4, "dx_in_box");
      expect_at(0, SIG_DY, 4, "dy_in_box");
      expect_at(1, SIG_ISF, 1, "is_frog_in_box");
      expect_at(1, SIG_COL, 5, "color_in_box");
      step(1);
      pif.DrawX = 10'd295;
      expect_at(0, SIG_DX, 0, "dx_left_of_box");
      expect_at(0, SIG_DY, 0, "dy_left_of_box");
      expect_at(1, SIG_ISF, 0, "is_frog_out_box");
      expect_at(1, SIG_COL, 0, "color_out_box");
      step(1);
      pif.DrawX = 10'd0; pif.DrawY = 10'd0; pif.rom_data = 8'd0;
      step(1);

      // down at Y_MAX: turn only
      tick(8'h16);
      expect_at(0, SIG_DIR, 2, "down_blocked_dir");
      expect_at(0, SIG_Y, 456, "down_blocked_y");
      tick(8'h00);

      // walk left to X_MIN, 12 full jumps
      for (int j = 1; j <= 12; j++) begin
         tick(8'h04);
         if (j == 1) expect_at(0, SIG_DIR, 7, "left_jump_dir");
         for (int k = 1; k <= 8; k++) tick(8'h04);
         expect_at(0, SIG_X, 296 - 24 * j, "left_jump_x");
         expect_at(0, SIG_DIR, 3, "left_end_dir");
         tick(8'h00);
      end

      tick(8'h16);
      expect_at(0, SIG_DIR, 2, "turn_down_at_xmin");
      tick(8'h00);
      tick(8'h04);
      expect_at(0, SIG_DIR, 3, "left_blocked_dir");
      expect_at(0, SIG_X, 8, "left_blocked_x");
      tick(8'h00);

      // up jump with per-frame positions
      tick(8'h1A);
      expect_at(0, SIG_DIR, 4, "up_start_dir");
      expect_at(0, SIG_Y, 456, "up_start_y");
      for (int k = 1; k <= 8; k++) begin
         tick(8'h1A);
         expect_at(0, SIG_Y, 456 - 3 * k, "up_step_y");
         expect_at(0, SIG_DIR, (k < 8) ? 4 : 0, "up_step_dir");
      end
`ifndef FROG_HOLD_REPEAT_EN
      repeat (2) tick(8'h1A);
      expect_at(0, SIG_Y, 432, "held_no_move_y");
      expect_at(0, SIG_DIR, 0, "held_no_move_dir");
`endif
      tick(8'h00);
      repeat (9) tick(8'h1A);
      expect_at(0, SIG_Y, 408, "second_jump_y");
      tick(8'h00);

      // reset in the middle of a jump
      do_reset();
      tick(8'h1A);
      repeat (4) tick(8'h1A);
      expect_at(0, SIG_Y, 444, "midjump_y");
      expect_at(0, SIG_DIR, 4, "midjump_dir");
      Reset = 1'b1;
      step(1);
      expect_at(0, SIG_Y, 456, "abort_y");
      expect_at(0, SIG_X, 296, "abort_x");
      expect_at(0, SIG_DIR, 0, "abort_dir");
      Reset = 1'b0;
      step(1);
      tick(8'h1A);
      expect_at(0, SIG_DIR, 4, "after_abort_jump_dir");
      expect_at(0, SIG_Y, 456, "after_abort_jump_y");

`ifdef FROG_HOLD_REPEAT_EN
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         tick(8'h07);
         if (k == 9)  expect_at(0, SIG_X, 320, "repeat_first_x");
         if (k == 18) expect_at(0, SIG_X, 344, "repeat_second_x");
      end
`endif

      step(3);
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         n_chk += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
